// File: rtl/sar_pkg.sv
// Shared constants and the round-half-up / saturate helper for SAR result post-processing.
package sar_pkg;

    localparam int unsigned SAR_DATA_W  = 8;
    localparam int unsigned SAR_OSR_MAX = 4;
    localparam int unsigned SAR_SUM_W   = SAR_DATA_W + SAR_OSR_MAX;
    localparam int unsigned SAR_RND_W   = SAR_SUM_W + 1;

    function automatic logic [SAR_DATA_W-1:0] sar_round_sat(
        input logic [SAR_SUM_W-1:0] sum,
        input int unsigned          osr_log2
    );
        logic [SAR_RND_W-1:0] w_t;
        if (osr_log2 == 0) begin
            return sum[SAR_DATA_W-1:0];
        end
        w_t = {1'b0, sum} + (SAR_RND_W'(1) << (osr_log2 - 1));
        w_t = w_t >> osr_log2;
        if (w_t > SAR_RND_W'((1 << SAR_DATA_W) - 1)) begin
            return '1;
        end
        return w_t[SAR_DATA_W-1:0];
    endfunction

endpackage

// File: rtl/sar_fwft_fifo.sv
// First-word-fall-through FIFO; a push while full is accepted only alongside a pop.
module sar_fwft_fifo #(
    parameter int unsigned DATA_W     = 8,
    parameter int unsigned DEPTH_LOG2 = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  push,
    input  logic [DATA_W-1:0]     push_data,
    input  logic                  pop,
    output logic [DATA_W-1:0]     head,
    output logic                  empty,
    output logic                  full,
    output logic [DEPTH_LOG2:0]   level
);

    localparam int unsigned DEPTH = 1 << DEPTH_LOG2;

    logic [DATA_W-1:0]     r_mem [DEPTH];
    logic [DEPTH_LOG2-1:0] r_wr_ptr;
    logic [DEPTH_LOG2-1:0] r_rd_ptr;
    logic [DEPTH_LOG2:0]   r_level;
    logic                  w_do_push;
    logic                  w_do_pop;

    assign empty     = (r_level == '0);
    assign full      = (r_level == (DEPTH_LOG2 + 1)'(DEPTH));
    assign w_do_pop  = pop & ~empty;
    assign w_do_push = push & (~full | w_do_pop);
    assign head      = r_mem[r_rd_ptr];
    assign level     = r_level;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                r_mem[i] <= '0;
            end
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_do_push) begin
                r_mem[r_wr_ptr] <= push_data;
                r_wr_ptr        <= r_wr_ptr + 1'b1;
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            r_level <= r_level + (DEPTH_LOG2 + 1)'(w_do_push) - (DEPTH_LOG2 + 1)'(w_do_pop);
        end
    end

endmodule

// File: rtl/sar_result_fifo.sv
// SAR result capture: eoc synchroniser, optional 2^OSR_LOG2 averager, FWFT result FIFO
// with sticky overflow.
module sar_result_fifo
    import sar_pkg::*;
#(
    parameter int unsigned DATA_W      = SAR_DATA_W,
    parameter int unsigned OSR_LOG2    = 2,
    parameter int unsigned DEPTH_LOG2  = 2,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic                  eoc_in,
    input  logic [DATA_W-1:0]     din,
    output logic [DATA_W-1:0]     out_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  ovf,
    input  logic                  ovf_clr,
    output logic [DEPTH_LOG2:0]   level
);

    localparam int unsigned ACC_W = DATA_W + OSR_LOG2;
    localparam int unsigned CNT_W = (OSR_LOG2 > 0) ? OSR_LOG2 : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((1 << OSR_LOG2) - 1);

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_hist;
    logic [ACC_W-1:0]       r_acc;
    logic [CNT_W-1:0]       r_cnt;
    logic [DATA_W-1:0]      r_res;
    logic                   r_push_pend;
    logic                   r_ovf;

    logic                   w_stb;
    logic                   w_sample;
    logic                   w_last;
    logic [ACC_W-1:0]       w_sum;
    logic [DATA_W-1:0]      w_res;
    logic                   w_empty;
    logic                   w_full;
    logic                   w_drop;
    logic                   w_ovf_d;

    assign w_stb    = r_sync[SYNC_STAGES-1] & ~r_hist;
    assign w_sample = w_stb & en;
    assign w_last   = (r_cnt == CNT_LAST);
    assign w_sum    = r_acc + ACC_W'(din);
    assign w_res    = sar_round_sat(SAR_SUM_W'(w_sum), OSR_LOG2);

    // Sync chain runs regardless of en so re-enabling mid-high eoc cannot fake an edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync      <= '0;
            r_hist      <= 1'b0;
            r_acc       <= '0;
            r_cnt       <= '0;
            r_res       <= '0;
            r_push_pend <= 1'b0;
            r_ovf       <= 1'b0;
        end else begin
            r_sync      <= {r_sync[SYNC_STAGES-2:0], eoc_in};
            r_hist      <= r_sync[SYNC_STAGES-1];
            r_push_pend <= w_sample & w_last;
            r_ovf       <= w_ovf_d;
            if (!en) begin
                r_acc <= '0;
                r_cnt <= '0;
            end else if (w_sample) begin
                if (w_last) begin
                    r_acc <= '0;
                    r_cnt <= '0;
                    r_res <= w_res;
                end else begin
                    r_acc <= w_sum;
                    r_cnt <= r_cnt + 1'b1;
                end
            end
        end
    end

    assign w_drop = r_push_pend & w_full & ~(out_ready & out_valid);

    always_comb begin
        w_ovf_d = r_ovf;
        if (ovf_clr) begin
            w_ovf_d = 1'b0;
        end
        if (w_drop) begin
            w_ovf_d = 1'b1;
        end
    end

    sar_fwft_fifo #(
        .DATA_W     (DATA_W),
        .DEPTH_LOG2 (DEPTH_LOG2)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (r_push_pend),
        .push_data (r_res),
        .pop       (out_ready),
        .head      (out_data),
        .empty     (w_empty),
        .full      (w_full),
        .level     (level)
    );

    assign out_valid = ~w_empty;
    assign ovf       = r_ovf;

endmodule

// File: tb/tb_sar_result_fifo.sv
// Directed bench: a pass-through instance (OSR_LOG2=0) and an averaging one (OSR_LOG2=2)
// share stimulus; each scenario checks the instance it targets.
module tb_sar_result_fifo;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       en = 1'b1;
    logic       eoc_in = 1'b0;
    logic [7:0] din = 8'h00;
    logic       out_ready = 1'b0;
    logic       ovf_clr = 1'b0;

    logic [7:0] d0_data;
    logic       d0_valid;
    logic       d0_ovf;
    logic [2:0] d0_level;
    logic [7:0] d2_data;
    logic       d2_valid;
    logic       d2_ovf;
    logic [2:0] d2_level;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    sar_result_fifo #(.DATA_W(8), .OSR_LOG2(0), .DEPTH_LOG2(2), .SYNC_STAGES(2)) u_dut0 (
        .clk(clk), .rst(rst), .en(en), .eoc_in(eoc_in), .din(din),
        .out_data(d0_data), .out_valid(d0_valid), .out_ready(out_ready),
        .ovf(d0_ovf), .ovf_clr(ovf_clr), .level(d0_level)
    );

    sar_result_fifo #(.DATA_W(8), .OSR_LOG2(2), .DEPTH_LOG2(2), .SYNC_STAGES(2)) u_dut2 (
        .clk(clk), .rst(rst), .en(en), .eoc_in(eoc_in), .din(din),
        .out_data(d2_data), .out_valid(d2_valid), .out_ready(out_ready),
        .ovf(d2_ovf), .ovf_clr(ovf_clr), .level(d2_level)
    );

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; en = 1'b1; eoc_in = 1'b0; out_ready = 1'b0; ovf_clr = 1'b0; din = 8'h00;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic conv(input logic [7:0] d);
        @(negedge clk);
        din = d; eoc_in = 1'b1;
        repeat (5) @(negedge clk);
        eoc_in = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic pop_one();
        @(negedge clk);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst = 1'b1;
        #1;
        checks++;
        if ({d0_valid, d0_ovf, d0_level, d0_data} !== 13'h0) begin
            errors++;
            $display("FAIL reset_dut0: got valid=%b ovf=%b level=%0d data=%h, want all 0",
                     d0_valid, d0_ovf, d0_level, d0_data);
        end
        checks++;
        if ({d2_valid, d2_ovf, d2_level, d2_data} !== 13'h0) begin
            errors++;
            $display("FAIL reset_dut2: got valid=%b ovf=%b level=%0d data=%h, want all 0",
                     d2_valid, d2_ovf, d2_level, d2_data);
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_passthrough();
        logic [7:0] vals [2];
        vals[0] = 8'h5A;
        vals[1] = 8'hC3;
        do_reset();
        out_ready = 1'b1;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            din = vals[k]; eoc_in = 1'b1;
            repeat (3) @(negedge clk);
            checks++;
            if (d0_valid !== 1'b0) begin
                errors++;
                $display("FAIL pt_early_valid[%0d]: got %b want 0", k, d0_valid);
            end
            @(negedge clk);
            checks++;
            if (d0_valid !== 1'b1 || d0_data !== vals[k]) begin
                errors++;
                $display("FAIL pt_data[%0d]: got valid=%b data=%h want 1/%h",
                         k, d0_valid, d0_data, vals[k]);
            end
            @(negedge clk);
            checks++;
            if (d0_valid !== 1'b0) begin
                errors++;
                $display("FAIL pt_single_valid[%0d]: got %b want 0", k, d0_valid);
            end
            eoc_in = 1'b0;
            repeat (3) @(negedge clk);
        end
    endtask

    task automatic test_average();
        logic [7:0] samples [12];
        logic [7:0] expect_res [3];
        samples = '{8'd10, 8'd11, 8'd11, 8'd11, 8'd255, 8'd255, 8'd255, 8'd255,
                    8'd1, 8'd1, 8'd1, 8'd2};
        expect_res = '{8'd11, 8'd255, 8'd1};
        do_reset();
        for (int g = 0; g < 3; g++) begin
            for (int s = 0; s < 4; s++) begin
                conv(samples[g*4 + s]);
            end
            checks++;
            if (d2_level !== 3'(g + 1)) begin
                errors++;
                $display("FAIL avg_level[%0d]: got %0d want %0d", g, d2_level, g + 1);
            end
        end
        for (int g = 0; g < 3; g++) begin
            checks++;
            if (d2_valid !== 1'b1 || d2_data !== expect_res[g]) begin
                errors++;
                $display("FAIL avg_result[%0d]: got valid=%b data=%0d want 1/%0d",
                         g, d2_valid, d2_data, expect_res[g]);
            end
            pop_one();
        end
    endtask

    task automatic test_overflow();
        do_reset();
        for (int i = 1; i <= 5; i++) begin
            conv(8'(i));
        end
        checks++;
        if (d0_level !== 3'd4 || d0_ovf !== 1'b1) begin
            errors++;
            $display("FAIL ovf_set: got level=%0d ovf=%b want 4/1", d0_level, d0_ovf);
        end
        // Dropped push coinciding with ovf_clr: set must win.
        @(negedge clk);
        din = 8'h66; eoc_in = 1'b1;
        repeat (3) @(negedge clk);
        ovf_clr = 1'b1;
        @(negedge clk);
        ovf_clr = 1'b0;
        checks++;
        if (d0_ovf !== 1'b1) begin
            errors++;
            $display("FAIL ovf_set_wins: got %b want 1", d0_ovf);
        end
        eoc_in = 1'b0;
        repeat (3) @(negedge clk);
        for (int i = 1; i <= 4; i++) begin
            checks++;
            if (d0_valid !== 1'b1 || d0_data !== 8'(i)) begin
                errors++;
                $display("FAIL ovf_drain[%0d]: got valid=%b data=%0d want 1/%0d",
                         i, d0_valid, d0_data, i);
            end
            pop_one();
        end
        checks++;
        if (d0_valid !== 1'b0 || d0_level !== 3'd0) begin
            errors++;
            $display("FAIL ovf_empty: got valid=%b level=%0d want 0/0", d0_valid, d0_level);
        end
        pop_one();
        checks++;
        if (d0_level !== 3'd0 || d0_ovf !== 1'b1) begin
            errors++;
            $display("FAIL empty_pop: got level=%0d ovf=%b want 0/1", d0_level, d0_ovf);
        end
        @(negedge clk);
        ovf_clr = 1'b1;
        @(negedge clk);
        ovf_clr = 1'b0;
        checks++;
        if (d0_ovf !== 1'b0) begin
            errors++;
            $display("FAIL ovf_clear: got %b want 0", d0_ovf);
        end
    endtask

    task automatic test_full_pop();
        logic [7:0] expect_q [4];
        expect_q = '{8'h02, 8'h03, 8'h04, 8'h77};
        do_reset();
        for (int i = 1; i <= 4; i++) begin
            conv(8'(i));
        end
        @(negedge clk);
        din = 8'h77; eoc_in = 1'b1;
        repeat (3) @(negedge clk);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        checks++;
        if (d0_level !== 3'd4 || d0_ovf !== 1'b0) begin
            errors++;
            $display("FAIL full_pop_level: got level=%0d ovf=%b want 4/0", d0_level, d0_ovf);
        end
        eoc_in = 1'b0;
        repeat (3) @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (d0_data !== expect_q[i]) begin
                errors++;
                $display("FAIL full_pop_order[%0d]: got %h want %h", i, d0_data, expect_q[i]);
            end
            pop_one();
        end
    endtask

    task automatic test_enable_abort();
        do_reset();
        conv(8'h20);
        conv(8'h20);
        @(negedge clk);
        en = 1'b0; din = 8'h99; eoc_in = 1'b1;
        repeat (3) @(negedge clk);
        en = 1'b1;
        repeat (3) @(negedge clk);
        eoc_in = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (d2_level !== 3'd0) begin
            errors++;
            $display("FAIL en_no_result: got level=%0d want 0", d2_level);
        end
        for (int s = 0; s < 4; s++) begin
            conv(8'h40);
        end
        checks++;
        if (d2_level !== 3'd1 || d2_data !== 8'h40) begin
            errors++;
            $display("FAIL en_abort_result: got level=%0d data=%h want 1/40", d2_level, d2_data);
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        for (int s = 0; s < 11; s++) begin
            conv(8'h05);
        end
        checks++;
        if (d2_level !== 3'd2 || d0_ovf !== 1'b1) begin
            errors++;
            $display("FAIL rm_before: got d2 level=%0d d0 ovf=%b want 2/1", d2_level, d0_ovf);
        end
        @(negedge clk);
        rst = 1'b1;
        #1;
        checks++;
        if (d2_valid !== 1'b0 || d2_level !== 3'd0 || d0_ovf !== 1'b0) begin
            errors++;
            $display("FAIL rm_async: got valid=%b level=%0d ovf=%b want 0/0/0",
                     d2_valid, d2_level, d0_ovf);
        end
        @(negedge clk);
        rst = 1'b0;
        for (int s = 0; s < 4; s++) begin
            conv(8'h10);
        end
        checks++;
        if (d2_level !== 3'd1 || d2_data !== 8'h10) begin
            errors++;
            $display("FAIL rm_after: got level=%0d data=%h want 1/10", d2_level, d2_data);
        end
    endtask

    initial begin
        test_reset();
        test_passthrough();
        test_average();
        test_overflow();
        test_full_pop();
        test_enable_abort();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
